// File: rtl/bf_loop_unit.sv
// bf_loop_unit: bracket resolver with a loop-head return stack and nested forward-skip mode
module bf_loop_unit #(
  parameter int IA_WIDTH   = 12,
  parameter int SP_WIDTH   = 4,
  parameter int NEST_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  input  logic                op_open,
  input  logic                op_close,
  input  logic                cell_zero,
  input  logic [IA_WIDTH-1:0] pc,
  output logic                op_ack,
  output logic                skip,
  output logic                jump,
  output logic [IA_WIDTH-1:0] jump_pc,
  output logic [SP_WIDTH:0]   depth,
  output logic                err_overflow,
  output logic                err_underflow
);
  typedef enum logic [1:0] {IDLE, SKIP, ERROR} state_e;
  localparam logic [SP_WIDTH:0] FULL = {1'b1, {SP_WIDTH{1'b0}}};
  state_e                state_q, state_d;
  logic [SP_WIDTH:0]     depth_q, depth_d;
  logic [NEST_WIDTH-1:0] nest_q, nest_d;
  logic                  skip_q, skip_d, jump_q, jump_d, ovf_q, ovf_d, unf_q, unf_d, push;
  logic [IA_WIDTH-1:0]   jump_pc_q, jump_pc_d;
  logic [IA_WIDTH-1:0]   stack_q [2**SP_WIDTH];
  logic [SP_WIDTH-1:0]   wr_idx, top_idx;
  logic                  acc, is_open, is_close;
  assign op_ack        = state_q != ERROR;
  assign acc           = op_valid && op_ack;
  assign is_open       = op_open && !op_close;
  assign is_close      = op_close && !op_open;
  assign wr_idx        = depth_q[SP_WIDTH-1:0];
  assign top_idx       = wr_idx - SP_WIDTH'(1);
  assign skip          = skip_q;
  assign jump          = jump_q;
  assign jump_pc       = jump_pc_q;
  assign depth         = depth_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  // next state: resolve the accepted bracket against the stack or the skip nesting count
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    nest_d    = nest_q;
    jump_d    = 1'b0;
    jump_pc_d = jump_pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    if (acc && state_q == IDLE && is_open) begin
      if (cell_zero) begin
        nest_d  = NEST_WIDTH'(1);
        state_d = SKIP;
      end else if (depth_q == FULL) begin
        ovf_d   = 1'b1;
        state_d = ERROR;
      end else begin
        push    = 1'b1;
        depth_d = depth_q + (SP_WIDTH+1)'(1);
      end
    end
    if (acc && state_q == IDLE && is_close) begin
      if (depth_q == '0) begin
        unf_d   = 1'b1;
        state_d = ERROR;
      end else if (cell_zero) begin
        depth_d = depth_q - (SP_WIDTH+1)'(1);
      end else begin
        jump_d    = 1'b1;
        jump_pc_d = stack_q[top_idx] + IA_WIDTH'(1);
      end
    end
    if (acc && state_q == SKIP && is_open) begin
      ovf_d   = nest_q == '1 ? 1'b1 : ovf_q;
      state_d = nest_q == '1 ? ERROR : SKIP;
      nest_d  = nest_q == '1 ? nest_q : nest_q + NEST_WIDTH'(1);
    end
    if (acc && state_q == SKIP && is_close) begin
      nest_d  = nest_q - NEST_WIDTH'(1);
      state_d = nest_q == NEST_WIDTH'(1) ? IDLE : SKIP;
    end
    skip_d = state_d == SKIP;
  end
  // control and status registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      depth_q   <= '0;
      nest_q    <= '0;
      skip_q    <= 1'b0;
      jump_q    <= 1'b0;
      jump_pc_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      nest_q    <= nest_d;
      skip_q    <= skip_d;
      jump_q    <= jump_d;
      jump_pc_q <= jump_pc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
  // loop-head storage; contents need no reset because depth gates every read
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_idx] <= pc;
  end
endmodule

// File: tb/tb_bf_loop_unit.sv
// tb_bf_loop_unit: scoreboarded check of bf_loop_unit against a queue-based loop model
module tb_bf_loop_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        op_valid = 1'b0, op_open = 1'b0, op_close = 1'b0, cell_zero = 1'b0;
  logic [11:0] pc = '0;
  logic        op_ack, skip, jump, err_overflow, err_underflow;
  logic [11:0] jump_pc;
  logic [4:0]  depth;
  int total = 0, bad = 0;
  typedef struct {
    logic        jump;
    logic [11:0] jpc;
    logic        skip;
    logic [4:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;
  exp_t sb[$];
  logic [11:0] m_stack[$];
  int   m_state = 0, m_nest = 0;
  logic m_ovf = 1'b0, m_unf = 1'b0;
  bf_loop_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_open(op_open), .op_close(op_close),
    .cell_zero(cell_zero), .pc(pc), .op_ack(op_ack), .skip(skip), .jump(jump),
    .jump_pc(jump_pc), .depth(depth), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic v, input logic o, input logic c, input logic cz, input logic [11:0] a, output exp_t e);
    logic op_o, op_c;
    op_o = v && o && !c && m_state != 2;
    op_c = v && c && !o && m_state != 2;
    e.jump = 1'b0;
    e.jpc  = '0;
    if (op_o && m_state == 0) begin
      if (cz) begin m_state = 1; m_nest = 1; end
      else if (m_stack.size() == 16) begin m_ovf = 1'b1; m_state = 2; end
      else m_stack.push_back(a);
    end else if (op_c && m_state == 0) begin
      if (m_stack.size() == 0) begin m_unf = 1'b1; m_state = 2; end
      else if (cz) void'(m_stack.pop_back());
      else begin e.jump = 1'b1; e.jpc = m_stack[m_stack.size()-1] + 12'd1; end
    end else if (op_o && m_state == 1) begin
      if (m_nest == 255) begin m_ovf = 1'b1; m_state = 2; end
      else m_nest++;
    end else if (op_c && m_state == 1) begin
      m_nest--;
      if (m_nest == 0) m_state = 0;
    end
    e.skip  = m_state == 1;
    e.depth = 5'(m_stack.size());
    e.ovf   = m_ovf;
    e.unf   = m_unf;
  endtask
  task automatic do_op(input logic v, input logic o, input logic c, input logic cz, input logic [11:0] a);
    exp_t e;
    @(negedge clk);
    op_valid = v; op_open = o; op_close = c; cell_zero = cz; pc = a;
    #1 chk("ack", op_ack, m_state != 2);
    model(v, o, c, cz, a, e);
    sb.push_back(e);
    @(posedge clk);
    #1 e = sb.pop_front();
    chk("jump", jump, e.jump);
    if (e.jump) chk("jump_pc", jump_pc, e.jpc);
    chk("skip", skip, e.skip);
    chk("depth", depth, e.depth);
    chk("ovf", err_overflow, e.ovf);
    chk("unf", err_underflow, e.unf);
  endtask
  task automatic do_reset();
    @(negedge clk);
    op_valid = 1'b0;
    reset = 1'b0;
    m_stack.delete();
    m_state = 0; m_nest = 0; m_ovf = 1'b0; m_unf = 1'b0;
    #2 chk("rst_ack", op_ack, 1);
    chk("rst_skip", skip, 0);
    chk("rst_jump", jump, 0);
    chk("rst_jpc", jump_pc, 0);
    chk("rst_depth", depth, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_unf", err_underflow, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    do_reset();
    // push / peek / pop
    do_op(1, 1, 0, 0, 12'h010);
    do_op(1, 0, 1, 0, 12'h020);
    do_op(1, 0, 1, 1, 12'h020);
    do_op(0, 0, 0, 0, 12'h000);
    // nested skip, with a both-high op ignored along the way
    do_op(1, 1, 0, 1, 12'h030);
    do_op(1, 1, 0, 0, 12'h031);
    do_op(1, 0, 0, 0, 12'h032);
    do_op(1, 1, 1, 0, 12'h033);
    do_op(1, 0, 1, 0, 12'h034);
    do_op(1, 0, 1, 1, 12'h035);
    do_op(1, 1, 0, 0, 12'h100);
    do_op(1, 0, 1, 0, 12'h110);
    do_op(1, 0, 1, 1, 12'h110);
    // wrap of the jump target
    do_op(1, 1, 0, 0, 12'hFFF);
    do_op(1, 0, 1, 0, 12'h200);
    do_op(1, 0, 1, 1, 12'h200);
    // back-to-back peeks give back-to-back pulses, then nested pops
    do_op(1, 1, 0, 0, 12'h050);
    do_op(1, 1, 0, 0, 12'h060);
    do_op(1, 0, 1, 0, 12'h070);
    do_op(1, 0, 1, 0, 12'h070);
    do_op(1, 0, 1, 1, 12'h070);
    do_op(1, 0, 1, 0, 12'h080);
    do_op(1, 0, 1, 1, 12'h080);
    // underflow
    do_op(1, 0, 1, 0, 12'h090);
    do_op(1, 1, 0, 0, 12'h091);
    do_reset();
    // stack overflow, then a close that must not be accepted
    for (int i = 0; i < 17; i++) do_op(1, 1, 0, 0, 12'(i + 1));
    do_op(1, 0, 1, 0, 12'h0A0);
    do_op(1, 0, 1, 1, 12'h0A0);
    do_reset();
    // nesting counter overflow
    do_op(1, 1, 0, 1, 12'h0B0);
    for (int i = 0; i < 255; i++) do_op(1, 1, 0, 0, 12'h0B1);
    do_op(1, 0, 1, 0, 12'h0B2);
    do_reset();
    // asynchronous reset mid-skip at nest 3
    do_op(1, 1, 0, 0, 12'h0C0);
    do_op(1, 1, 0, 1, 12'h0C1);
    do_op(1, 1, 0, 0, 12'h0C2);
    do_op(1, 1, 0, 0, 12'h0C3);
    do_reset();
    do_op(1, 1, 0, 0, 12'h0D0);
    do_op(1, 0, 1, 0, 12'h0D1);
    do_op(1, 0, 1, 1, 12'h0D1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
